// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display blocks: segment word type,
// digit count and the hex glyph table in {g,f,e,d,c,b,a} bit order.
package seg_pkg;

    typedef logic [7:0] seg_t;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] HEX_PAT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-nibble to seven-segment glyph decoder (full 0-F set).
// Shared with the board-level status display.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    // Table lookup of the glyph for the selected nibble
    always_comb begin
        pattern = HEX_PAT[nibble];
    end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment scan driver. A 16-bit word from the
// core is shadowed on load and copied to the display register only at frame
// boundaries so a frame never tears. Each digit slot begins with a blank
// window to suppress ghosting; the decimal points mirror the core halt level.
module seg7_scan
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int BLANK    = 500
) (
    input  logic        board_ck,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        halt,
    output logic [7:0]  SEG,
    output logic [3:0]  SEG_SEL
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [CNT_W-1:0] cnt;
    logic [1:0]       digit;
    logic [15:0]      shadow;
    logic [15:0]      disp;

    logic             slot_end;
    logic             frame_end;
    logic             blank_phase;
    logic [3:0]       nibble;
    logic [6:0]       pattern;

    assign slot_end    = (cnt == CNT_W'(SCAN_DIV - 1));
    assign frame_end   = slot_end && (digit == 2'(NUM_DIGITS - 1));
    assign blank_phase = (cnt < CNT_W'(BLANK));
    assign nibble      = disp[{digit, 2'b00} +: 4];

    seg7_decode u_decode (
        .nibble  (nibble),
        .pattern (pattern)
    );

    // Slot timer and digit pointer; digit advances when the slot timer wraps
    always_ff @(posedge board_ck) begin
        if (rst) begin
            cnt   <= '0;
            digit <= '0;
        end else if (slot_end) begin
            cnt   <= '0;
            digit <= digit + 2'd1;
        end else begin
            cnt   <= cnt + CNT_W'(1);
        end
    end

    // Shadow capture on load; display word only refreshed at a frame boundary,
    // taking the incoming value directly when a load lands on that cycle
    always_ff @(posedge board_ck) begin
        if (rst) begin
            shadow <= '0;
            disp   <= '0;
        end else begin
            if (load) begin
                shadow <= value;
            end
            if (frame_end) begin
                disp <= load ? value : shadow;
            end
        end
    end

    // Registered pin drive: blank window forces everything dark, otherwise
    // enable the current digit and show its glyph with halt on the dp
    always_ff @(posedge board_ck) begin
        if (rst) begin
            SEG     <= '0;
            SEG_SEL <= '0;
        end else if (blank_phase) begin
            SEG     <= '0;
            SEG_SEL <= '0;
        end else begin
            SEG     <= seg_t'({halt, pattern});
            SEG_SEL <= 4'(1) << digit;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Testbench for seg7_scan with SCAN_DIV=4, BLANK=1. A behavioural model
// driven by a cycle count since reset release predicts the pins every cycle.
module tb_seg7_scan;

    localparam int SD    = 4;
    localparam int BL    = 1;
    localparam int FRAME = 4 * SD;

    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        board_ck = 1'b0;
    logic        rst      = 1'b1;
    logic [15:0] value    = '0;
    logic        load     = 1'b0;
    logic        halt     = 1'b0;
    logic [7:0]  SEG;
    logic [3:0]  SEG_SEL;

    int n_checks = 0;
    int n_errors = 0;

    // model state
    int          m_k      = 0;
    logic [15:0] m_shadow = '0;
    logic [15:0] m_disp   = '0;
    logic [7:0]  exp_seg  = '0;
    logic [3:0]  exp_sel  = '0;

    seg7_scan #(.SCAN_DIV(SD), .BLANK(BL)) dut (
        .board_ck (board_ck),
        .rst      (rst),
        .value    (value),
        .load     (load),
        .halt     (halt),
        .SEG      (SEG),
        .SEG_SEL  (SEG_SEL)
    );

    always #5 board_ck = ~board_ck;

    // One clock: drive inputs, predict the pins after the edge, advance model
    task automatic tick(input logic r, input logic l, input logic [15:0] v, input logic h);
        int pos;
        int dig;
        logic [3:0] nib;
        @(negedge board_ck);
        rst = r; load = l; value = v; halt = h;
        pos = m_k % SD;
        dig = (m_k / SD) % 4;
        if (r || pos < BL) begin
            exp_seg = 8'h00;
            exp_sel = 4'h0;
        end else begin
            nib     = m_disp[dig*4 +: 4];
            exp_seg = {h, GLYPH[nib]};
            exp_sel = 4'b0001 << dig;
        end
        if (r) begin
            m_k = 0; m_shadow = '0; m_disp = '0;
        end else begin
            if ((m_k % FRAME) == FRAME - 1) m_disp = l ? v : m_shadow;
            if (l) m_shadow = v;
            m_k++;
        end
        @(posedge board_ck);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 16'h0, 1'b0);
            n_checks++;
            if (SEG !== 8'h00 || SEG_SEL !== 4'h0) begin
                n_errors++;
                $display("FAIL reset_hold seg=%h sel=%h want seg=00 sel=0", SEG, SEG_SEL);
            end
        end
        tick(1'b0, 1'b0, 16'h0, 1'b0);
        n_checks++;
        if (SEG !== 8'h00 || SEG_SEL !== 4'h0) begin
            n_errors++;
            $display("FAIL reset_release seg=%h sel=%h want seg=00 sel=0", SEG, SEG_SEL);
        end
    endtask

    task automatic test_scan_zero();
        logic [3:0] seq [16] = '{4'h0,4'h1,4'h1,4'h1, 4'h0,4'h2,4'h2,4'h2,
                                 4'h0,4'h4,4'h4,4'h4, 4'h0,4'h8,4'h8,4'h8};
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick(1'b0, 1'b0, 16'h0, 1'b0);
            n_checks++;
            if (SEG !== exp_seg || SEG_SEL !== exp_sel) begin
                n_errors++;
                $display("FAIL scan_zero k=%0d seg=%h sel=%h want seg=%h sel=%h", m_k, SEG, SEG_SEL, exp_seg, exp_sel);
            end
            // output at this point reflects cycle m_k-1 of the scan
            n_checks++;
            if (SEG_SEL !== seq[(m_k - 1) % FRAME] || SEG !== ((SEG_SEL != 0) ? 8'h3F : 8'h00)) begin
                n_errors++;
                $display("FAIL scan_seq k=%0d seg=%h sel=%h want sel=%h", m_k, SEG, SEG_SEL, seq[(m_k - 1) % FRAME]);
            end
        end
    endtask

    task automatic test_load_midframe();
        while ((m_k % FRAME) != 5) tick(1'b0, 1'b0, 16'h0, 1'b0);
        tick(1'b0, 1'b1, 16'h1A2F, 1'b0);
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick(1'b0, 1'b0, 16'h0, 1'b0);
            n_checks++;
            if (SEG !== exp_seg || SEG_SEL !== exp_sel) begin
                n_errors++;
                $display("FAIL load_mid k=%0d seg=%h sel=%h want seg=%h sel=%h", m_k, SEG, SEG_SEL, exp_seg, exp_sel);
            end
        end
    endtask

    task automatic test_load_boundary();
        while ((m_k % FRAME) != 3) tick(1'b0, 1'b0, 16'h0, 1'b0);
        tick(1'b0, 1'b1, 16'h1111, 1'b0);
        while ((m_k % FRAME) != FRAME - 1) tick(1'b0, 1'b0, 16'h0, 1'b0);
        tick(1'b0, 1'b1, 16'h0007, 1'b0);
        for (int i = 0; i < FRAME; i++) begin
            tick(1'b0, 1'b0, 16'h0, 1'b0);
            n_checks++;
            if (SEG !== exp_seg || SEG_SEL !== exp_sel) begin
                n_errors++;
                $display("FAIL load_boundary k=%0d seg=%h sel=%h want seg=%h sel=%h", m_k, SEG, SEG_SEL, exp_seg, exp_sel);
            end
            if (SEG_SEL == 4'h1) begin
                n_checks++;
                if (SEG !== 8'h07) begin
                    n_errors++;
                    $display("FAIL boundary_digit0 seg=%h want 07", SEG);
                end
            end
        end
    endtask

    task automatic test_halt();
        while ((m_k % FRAME) != 10) tick(1'b0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < FRAME + 4; i++) begin
            tick(1'b0, 1'b0, 16'h0, 1'b1);
            n_checks++;
            if (SEG !== exp_seg || SEG_SEL !== exp_sel) begin
                n_errors++;
                $display("FAIL halt k=%0d seg=%h sel=%h want seg=%h sel=%h", m_k, SEG, SEG_SEL, exp_seg, exp_sel);
            end
            n_checks++;
            if (SEG[7] !== (SEG_SEL != 4'h0)) begin
                n_errors++;
                $display("FAIL halt_dp k=%0d dp=%b sel=%h", m_k, SEG[7], SEG_SEL);
            end
        end
        tick(1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic test_reset_midslot();
        while ((m_k % FRAME) != 4) tick(1'b0, 1'b0, 16'h0, 1'b0);
        tick(1'b0, 1'b1, 16'hFFFF, 1'b0);
        while ((m_k % FRAME) != 6) tick(1'b0, 1'b0, 16'h0, 1'b0);
        tick(1'b0, 1'b1, 16'hABCD, 1'b0);
        tick(1'b1, 1'b0, 16'h0, 1'b0);
        n_checks++;
        if (SEG !== 8'h00 || SEG_SEL !== 4'h0) begin
            n_errors++;
            $display("FAIL reset_mid seg=%h sel=%h want seg=00 sel=0", SEG, SEG_SEL);
        end
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick(1'b0, 1'b0, 16'h0, 1'b0);
            n_checks++;
            if (SEG !== exp_seg || SEG_SEL !== exp_sel) begin
                n_errors++;
                $display("FAIL reset_restart k=%0d seg=%h sel=%h want seg=%h sel=%h", m_k, SEG, SEG_SEL, exp_seg, exp_sel);
            end
            n_checks++;
            if (SEG_SEL != 4'h0 && SEG !== 8'h3F) begin
                n_errors++;
                $display("FAIL reset_discard k=%0d seg=%h want 3F", m_k, SEG);
            end
        end
    endtask

    task automatic test_back_to_back();
        while ((m_k % FRAME) != 7) tick(1'b0, 1'b0, 16'h0, 1'b0);
        tick(1'b0, 1'b1, 16'h1234, 1'b0);
        tick(1'b0, 1'b1, 16'h5678, 1'b0);
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick(1'b0, 1'b0, 16'h0, 1'b0);
            n_checks++;
            if (SEG !== exp_seg || SEG_SEL !== exp_sel) begin
                n_errors++;
                $display("FAIL back_to_back k=%0d seg=%h sel=%h want seg=%h sel=%h", m_k, SEG, SEG_SEL, exp_seg, exp_sel);
            end
        end
    endtask

    task automatic test_random();
        logic h = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) h = ~h;
            tick(($urandom_range(0, 79) == 0), ($urandom_range(0, 5) == 0), 16'($urandom), h);
            n_checks++;
            if (SEG !== exp_seg || SEG_SEL !== exp_sel) begin
                n_errors++;
                $display("FAIL random k=%0d seg=%h sel=%h want seg=%h sel=%h", m_k, SEG, SEG_SEL, exp_seg, exp_sel);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_zero();
        test_load_midframe();
        test_load_boundary();
        test_halt();
        test_reset_midslot();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
